// File: rtl/div_unit_iter.sv
// Iterative RV32M divide/remainder unit: restoring shift-subtract, one quotient bit per cycle.
// Results are presented on a register-file write port (wd/wa/we) with a start/busy/done handshake.
module div_unit_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_idx,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] wd,
  output logic [4:0]      wa,
  output logic            we
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sel_rem;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvs;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_spec_val;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_trial;
  logic              w_qbit;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_res;
  logic [4:0]        w_res_wa;

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_signed = !op[0];
  assign w_a_neg  = w_signed && rs1_val[XLEN-1];
  assign w_b_neg  = w_signed && rs2_val[XLEN-1];
  assign w_a_abs  = w_a_neg ? (~rs1_val + {{(XLEN-1){1'b0}}, 1'b1}) : rs1_val;
  assign w_b_abs  = w_b_neg ? (~rs2_val + {{(XLEN-1){1'b0}}, 1'b1}) : rs2_val;
  assign w_div0   = (rs2_val == {XLEN{1'b0}});
  assign w_ovf    = w_signed && (rs1_val == INT_MIN) && (rs2_val == ALL_ONES);
  assign w_special = w_div0 || w_ovf;

  // Divide-by-zero returns the raw dividend as remainder; signed overflow wraps to INT_MIN.
  always_comb begin
    w_spec_val = {XLEN{1'b0}};
    if (w_div0) begin
      w_spec_val = op[1] ? rs1_val : ALL_ONES;
    end else begin
      w_spec_val = op[1] ? {XLEN{1'b0}} : INT_MIN;
    end
  end

  // The dividend shifts out of r_quo MSB-first while quotient bits shift in at the bottom.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_qbit  = !w_trial[XLEN];

  assign w_quo_fix = r_neg_q ? (~r_quo + {{(XLEN-1){1'b0}}, 1'b1}) : r_quo;
  assign w_rem_fix = r_neg_r ? (~r_rem + {{(XLEN-1){1'b0}}, 1'b1}) : r_rem;
  assign w_res     = (r_state == S_IDLE) ? w_spec_val : (r_sel_rem ? w_rem_fix : w_quo_fix);
  assign w_res_wa  = (r_state == S_IDLE) ? rd_idx : r_rd;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_special ? S_DONE : S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = S_FIX;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_rem <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rd      <= 5'd0;
      r_quo     <= {XLEN{1'b0}};
      r_rem     <= {XLEN{1'b0}};
      r_dvs     <= {XLEN{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_sel_rem <= op[1];
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
      r_rd      <= rd_idx;
      r_quo     <= w_a_abs;
      r_rem     <= {XLEN{1'b0}};
      r_dvs     <= w_b_abs;
      r_cnt     <= CNT_W'(XLEN - 1);
    end else if (r_state == S_CALC) begin
      r_rem <= w_qbit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_qbit};
      if (r_cnt != {CNT_W{1'b0}}) begin
        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Write-port outputs: wd/wa only move when a result is delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      we   <= 1'b0;
      wd   <= {XLEN{1'b0}};
      wa   <= 5'd0;
    end else begin
      busy <= (w_state_nxt != S_IDLE);
      done <= (w_state_nxt == S_DONE);
      we   <= (w_state_nxt == S_DONE) && (w_res_wa != 5'd0);
      if (w_state_nxt == S_DONE) begin
        wd <= w_res;
        wa <= w_res_wa;
      end
    end
  end

endmodule
